// File: rtl/uniboard_bus_pkg.sv
// rtl/uniboard_bus_pkg.sv - shared types and widths for the Uniboard peripheral register bus
package uniboard_bus_pkg;

  localparam int BUS_DATA_W = 32;
  localparam int REG_ADDR_W = 8;
  localparam int SIZE_W     = 3;
  localparam int NUM_PERIPH = 128;
  localparam int PERIPH_W   = $clog2(NUM_PERIPH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE1,
    S_STROBE2,
    S_RELEASE,
    S_DONE
  } bus_state_t;

endpackage

// File: rtl/peripheral_bus_arbiter_if.sv
// rtl/peripheral_bus_arbiter_if.sv - peripheral-side register bus bundle
interface peripheral_bus_arbiter_if;
  import uniboard_bus_pkg::*;

  logic [BUS_DATA_W-1:0] bus_wdata;
  logic                  bus_oe;
  logic [BUS_DATA_W-1:0] bus_rdata;
  logic [SIZE_W-1:0]     bus_size;
  logic [REG_ADDR_W-1:0] reg_addr;
  logic                  rw;
  logic [NUM_PERIPH-1:0] select;

  modport master (
    output bus_wdata, bus_oe, reg_addr, rw, select,
    input  bus_rdata, bus_size
  );

  modport slave (
    input  bus_wdata, bus_oe, reg_addr, rw, select,
    output bus_rdata, bus_size
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner search starting after the last grant
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] cand;

  // Walk ptr+1, ptr+2, ... wrapping at NREQ; first asserted request wins.
  always_comb begin
    any   = 1'b0;
    grant = '0;
    idx   = '0;
    cand  = (ptr == IW'(NREQ - 1)) ? '0 : ptr + IW'(1);
    for (int k = 0; k < NREQ; k++) begin
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
      cand = (cand == IW'(NREQ - 1)) ? '0 : cand + IW'(1);
    end
  end

endmodule

// File: rtl/peripheral_bus_arbiter.sv
// rtl/peripheral_bus_arbiter.sv - round-robin master arbiter and fixed-timing transaction sequencer
module peripheral_bus_arbiter
  import uniboard_bus_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                             clk_12MHz,
  input  logic                             reset_n,
  input  logic [NREQ-1:0]                  req,
  input  logic [NREQ-1:0]                  req_rw,
  input  logic [NREQ-1:0][PERIPH_W-1:0]    req_periph,
  input  logic [NREQ-1:0][REG_ADDR_W-1:0]  req_addr,
  input  logic [NREQ-1:0][BUS_DATA_W-1:0]  req_wdata,
  output logic [NREQ-1:0]                  done,
  output logic [BUS_DATA_W-1:0]            rdata,
  output logic [SIZE_W-1:0]                rsize,
  output logic                             rerr,
  output logic                             busy,
  peripheral_bus_arbiter_if.master         bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  bus_state_t            state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [NREQ-1:0]       win_q, win_d;
  logic [PERIPH_W-1:0]   periph_q, periph_d;
  logic                  rw_q, rw_d;
  logic                  oe_q, oe_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [BUS_DATA_W-1:0] wdata_q, wdata_d;
  logic [BUS_DATA_W-1:0] rdata_q, rdata_d;
  logic [NUM_PERIPH-1:0] sel_q, sel_d;
  logic [NREQ-1:0]       done_q, done_d;
  logic [SIZE_W-1:0]     rsize_q, rsize_d;
  logic                  rerr_q, rerr_d;

  logic                  pick_any;
  logic [NREQ-1:0]       pick_grant;
  logic [IW-1:0]         pick_idx;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .any   (pick_any),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk_12MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= IW'(NREQ - 1);
      win_q    <= '0;
      periph_q <= '0;
      rw_q     <= 1'b1;
      oe_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      sel_q    <= '0;
      done_q   <= '0;
      rsize_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      periph_q <= periph_d;
      rw_q     <= rw_d;
      oe_q     <= oe_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      sel_q    <= sel_d;
      done_q   <= done_d;
      rsize_q  <= rsize_d;
      rerr_q   <= rerr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    periph_d = periph_q;
    rw_d     = rw_q;
    oe_d     = oe_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    sel_d    = sel_q;
    done_d   = '0;
    rsize_d  = rsize_q;
    rerr_d   = rerr_q;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          win_d    = pick_grant;
          ptr_d    = pick_idx;
          periph_d = req_periph[pick_idx];
          rw_d     = req_rw[pick_idx];
          oe_d     = ~req_rw[pick_idx];
          addr_d   = req_addr[pick_idx];
          wdata_d  = req_wdata[pick_idx];
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        sel_d           = '0;
        sel_d[periph_q] = 1'b1;
        state_d         = S_STROBE1;
      end
      S_STROBE1: state_d = S_STROBE2;
      S_STROBE2: begin
        // rw_q still holds the latched direction here; it only returns to 1 in RELEASE.
        if (rw_q) begin
          rdata_d = bus.bus_rdata;
          rsize_d = bus.bus_size;
          rerr_d  = (bus.bus_size == '0);
        end
        sel_d   = '0;
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        oe_d    = 1'b0;
        rw_d    = 1'b1;
        done_d  = win_q;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign done          = done_q;
  assign rdata         = rdata_q;
  assign rsize         = rsize_q;
  assign rerr          = rerr_q;
  assign busy          = (state_q != S_IDLE);
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_oe    = oe_q;
  assign bus.reg_addr  = addr_q;
  assign bus.rw        = rw_q;
  assign bus.select    = sel_q;

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// tb/tb_peripheral_bus_arbiter.sv - directed table-driven bench for peripheral_bus_arbiter
module tb_peripheral_bus_arbiter;

  logic             clk;
  logic             reset_n;
  logic [1:0]       req;
  logic [1:0]       req_rw;
  logic [1:0][6:0]  req_periph;
  logic [1:0][7:0]  req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       done;
  logic [31:0]      rdata;
  logic [2:0]       rsize;
  logic             rerr;
  logic             busy;

  int checks = 0;
  int errors = 0;

  peripheral_bus_arbiter_if bus_if ();

  peripheral_bus_arbiter #(.NREQ(2)) dut (
    .clk_12MHz  (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_rw     (req_rw),
    .req_periph (req_periph),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .done       (done),
    .rdata      (rdata),
    .rsize      (rsize),
    .rerr       (rerr),
    .busy       (busy),
    .bus        (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        who;
    logic [6:0]  periph;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] resp_data;
    logic [2:0]  resp_size;
    logic [31:0] exp_rdata;
    logic [2:0]  exp_rsize;
    logic        exp_rerr;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    logic [127:0] oh;
    logic [1:0]   dexp;
    oh   = 128'd1 << v.periph;
    dexp = v.who ? 2'b10 : 2'b01;
    req_rw[v.who]     = v.rd;
    req_periph[v.who] = v.periph;
    req_addr[v.who]   = v.addr;
    req_wdata[v.who]  = v.wdata;
    bus_if.bus_rdata  = v.resp_data;
    bus_if.bus_size   = v.resp_size;
    req[v.who]        = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      if (c <= 4) begin
        chk($sformatf("c%0d_select", c), bus_if.select, (c == 2 || c == 3) ? oh : 128'd0);
        chk($sformatf("c%0d_oe", c), {127'd0, bus_if.bus_oe}, {127'd0, ~v.rd});
        chk($sformatf("c%0d_rw", c), {127'd0, bus_if.rw}, {127'd0, v.rd});
        chk($sformatf("c%0d_addr", c), {120'd0, bus_if.reg_addr}, {120'd0, v.addr});
        chk($sformatf("c%0d_wdata", c), {96'd0, bus_if.bus_wdata}, {96'd0, v.wdata});
        chk($sformatf("c%0d_busy", c), {127'd0, busy}, 128'd1);
        chk($sformatf("c%0d_done", c), {126'd0, done}, 128'd0);
      end else if (c == 5) begin
        chk("c5_done", {126'd0, done}, {126'd0, dexp});
        chk("c5_rdata", {96'd0, rdata}, {96'd0, v.exp_rdata});
        chk("c5_rsize", {125'd0, rsize}, {125'd0, v.exp_rsize});
        chk("c5_rerr", {127'd0, rerr}, {127'd0, v.exp_rerr});
        chk("c5_oe", {127'd0, bus_if.bus_oe}, 128'd0);
        chk("c5_rw", {127'd0, bus_if.rw}, 128'd1);
        chk("c5_select", bus_if.select, 128'd0);
        req[v.who] = 1'b0;
      end else begin
        chk("c6_done", {126'd0, done}, 128'd0);
        chk("c6_busy", {127'd0, busy}, 128'd0);
      end
    end
  endtask

  task automatic wait_done(input string name, input int limit, output logic [1:0] d, output int n);
    d = 2'b00;
    n = 0;
    while (d == 2'b00 && n < limit) begin
      cyc();
      n++;
      d = done;
    end
    if (d == 2'b00) chk({name, "_timeout"}, 128'd0, 128'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      cyc();
      n++;
    end
    chk("wait_idle", {127'd0, busy}, 128'd0);
  endtask

  initial begin
    logic [1:0] d;
    int         n;
    int         stamp [4];
    logic [1:0] seen  [4];
    int         cnt;

    vecs[0] = '{1'b0, 1'b0, 7'd2,   8'h05, 32'hDEADBEEF, 32'h0,        3'd0, 32'h0,        3'd0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 7'd2,   8'h01, 32'h0,        32'h12345678, 3'd2, 32'h12345678, 3'd2, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 7'd100, 8'h10, 32'h0,        32'hA5A5A5A5, 3'd0, 32'hA5A5A5A5, 3'd0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 7'd127, 8'hFF, 32'h0BADF00D, 32'h55555555, 3'd7, 32'hA5A5A5A5, 3'd0, 1'b1};

    reset_n          = 1'b0;
    req              = '0;
    req_rw           = '0;
    req_periph       = '0;
    req_addr         = '0;
    req_wdata        = '0;
    bus_if.bus_rdata = '0;
    bus_if.bus_size  = '0;
    cyc();
    cyc();
    chk("rst_done", {126'd0, done}, 128'd0);
    chk("rst_rdata", {96'd0, rdata}, 128'd0);
    chk("rst_rsize", {125'd0, rsize}, 128'd0);
    chk("rst_rerr", {127'd0, rerr}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_oe", {127'd0, bus_if.bus_oe}, 128'd0);
    chk("rst_rw", {127'd0, bus_if.rw}, 128'd1);
    chk("rst_addr", {120'd0, bus_if.reg_addr}, 128'd0);
    chk("rst_wdata", {96'd0, bus_if.bus_wdata}, 128'd0);
    chk("rst_select", bus_if.select, 128'd0);
    reset_n = 1'b1;
    cyc();

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Contention after a fresh reset: requester 0 first, then strict alternation.
    reset_n = 1'b0;
    cyc();
    reset_n    = 1'b1;
    req_rw     = 2'b00;
    req_periph = {7'd4, 7'd3};
    req        = 2'b11;
    cnt        = 0;
    for (int c = 1; c <= 30 && cnt < 4; c++) begin
      cyc();
      if (done != 2'b00) begin
        stamp[cnt] = c;
        seen[cnt]  = done;
        cnt++;
      end
    end
    chk("cont_count", cnt, 4);
    if (cnt == 4) begin
      chk("cont_first_cycle", stamp[0], 5);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("cont_grant%0d", i), {126'd0, seen[i]}, (i % 2 == 0) ? 128'd1 : 128'd2);
        if (i > 0) chk($sformatf("cont_gap%0d", i), stamp[i] - stamp[i-1], 6);
      end
    end
    req = 2'b00;
    wait_idle();

    // Reset during STROBE1 of a write.
    req_rw[0]     = 1'b0;
    req_periph[0] = 7'd2;
    req           = 2'b01;
    cyc();
    cyc();
    chk("mid_sel_before", bus_if.select, 128'd4);
    chk("mid_oe_before", {127'd0, bus_if.bus_oe}, 128'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_sel_async", bus_if.select, 128'd0);
    chk("mid_oe_async", {127'd0, bus_if.bus_oe}, 128'd0);
    chk("mid_busy_async", {127'd0, busy}, 128'd0);
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk($sformatf("mid_nodone%0d", c), {126'd0, done}, 128'd0);
    end
    req     = 2'b11;
    reset_n = 1'b1;
    wait_done("mid_first", 20, d, n);
    chk("mid_first_grant", {126'd0, d}, 128'd1);
    chk("mid_first_cycle", n, 5);
    req[0] = 1'b0;
    wait_done("mid_second", 20, d, n);
    chk("mid_second_grant", {126'd0, d}, 128'd2);
    req = 2'b00;
    wait_idle();

    // Requester 0 withdraws during SETUP; the transaction still runs to completion.
    req = 2'b01;
    cyc();
    req = 2'b00;
    for (int c = 2; c <= 5; c++) begin
      cyc();
      if (c == 2 || c == 3) chk($sformatf("drop_sel_c%0d", c), bus_if.select, 128'd4);
      if (c == 5) chk("drop_done_c5", {126'd0, done}, 128'd1);
    end
    cyc();
    chk("drop_idle", {127'd0, busy}, 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
